// File: rtl/clangpu_pkg.sv
// clangpu_pkg: shared instruction widths and the fetch/decode word type
package clangpu_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } inst_t;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-side push, decode-side pop and status signals of the fetch queue
interface fetch_queue_if #(
  parameter int DEPTH = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic I_VALID;
  logic [ADDR_WIDTH-1:0] I_ADDR;
  logic [DATA_WIDTH-1:0] I_DATA;
  logic O_STALL;
  logic I_FLUSH;
  logic O_VALID;
  logic [ADDR_WIDTH-1:0] O_ADDR;
  logic [DATA_WIDTH-1:0] O_DATA;
  logic I_READY;
  logic [$clog2(DEPTH):0] O_COUNT;
  logic O_OVERFLOW;
  modport master (
    output I_VALID, I_ADDR, I_DATA, I_FLUSH, I_READY,
    input O_STALL, O_VALID, O_ADDR, O_DATA, O_COUNT, O_OVERFLOW
  );
  modport slave (
    input I_VALID, I_ADDR, I_DATA, I_FLUSH, I_READY,
    output O_STALL, O_VALID, O_ADDR, O_DATA, O_COUNT, O_OVERFLOW
  );
endinterface

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrapping read/write pointers and occupancy counter with flush/reset clear
module fifo_ptr #(
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst,
  input logic flush,
  input logic push,
  input logic pop,
  output logic [$clog2(DEPTH)-1:0] wr_ptr,
  output logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] count_next
);
  // occupancy after this edge; simultaneous push and pop leave it unchanged
  always_comb count_next = (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
  // pointers wrap naturally at DEPTH because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: FWFT instruction buffer between fetch and decode with early stall and flush
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int ADDR_WIDTH = clangpu_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = clangpu_pkg::DATA_WIDTH,
  parameter int SKID = 2
) (
  input logic CCLK,
  input logic CRST,
  fetch_queue_if.slave bus
);
  import clangpu_pkg::*;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] STALL_AT = (AW+1)'(DEPTH - SKID);
  inst_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_next;
  logic push, pop, full;
  logic stall, overflow;
  // a full buffer still accepts a word when the head leaves in the same cycle
  always_comb begin
    full = count == FULL;
    pop = (count != '0) && bus.I_READY && !bus.I_FLUSH;
    push = bus.I_VALID && !bus.I_FLUSH && (!full || pop);
  end
  fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk(CCLK),
    .rst(CRST),
    .flush(bus.I_FLUSH),
    .push(push),
    .pop(pop),
    .wr_ptr(wr_ptr),
    .rd_ptr(rd_ptr),
    .count(count),
    .count_next(count_next)
  );
  // storage has no reset so it maps onto distributed RAM
  always_ff @(posedge CCLK) begin
    if (push) mem[wr_ptr] <= '{addr: bus.I_ADDR, data: bus.I_DATA};
  end
  // stall raised early enough that SKID in-flight words still fit
  always_ff @(posedge CCLK) begin
    if (CRST || bus.I_FLUSH) stall <= 1'b0;
    else stall <= count_next >= STALL_AT;
  end
  // sticky record of a word arriving into a full buffer with no pop to make room
  always_ff @(posedge CCLK) begin
    if (CRST) overflow <= 1'b0;
    else if (bus.I_VALID && !bus.I_FLUSH && full && !pop) overflow <= 1'b1;
  end
  assign bus.O_VALID = count != '0;
  assign bus.O_ADDR = mem[rd_ptr].addr;
  assign bus.O_DATA = mem[rd_ptr].data;
  assign bus.O_COUNT = count;
  assign bus.O_STALL = stall;
  assign bus.O_OVERFLOW = overflow;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed checks of fetch_queue against a queue-based model
module tb_fetch_queue;
  localparam int DEPTH = 8;
  localparam int SKID = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [63:0] q[$];
  logic m_stall = 1'b0;
  logic m_ovf = 1'b0;
  logic [31:0] popped[$];
  fetch_queue_if #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32), .SKID(SKID)) dut (
    .CCLK(clk),
    .CRST(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_outputs();
    chk("valid", 64'(bus.O_VALID), 64'(q.size() != 0));
    chk("count", 64'(bus.O_COUNT), 64'(q.size()));
    chk("stall", 64'(bus.O_STALL), 64'(m_stall));
    chk("overflow", 64'(bus.O_OVERFLOW), 64'(m_ovf));
    if (q.size() != 0) begin
      chk("head_addr", 64'(bus.O_ADDR), 64'(q[0][63:32]));
      chk("head_data", 64'(bus.O_DATA), 64'(q[0][31:0]));
    end
  endtask
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d, input logic f, input logic r);
    logic mpop, mpush;
    bus.I_VALID = v;
    bus.I_ADDR = a;
    bus.I_DATA = d;
    bus.I_FLUSH = f;
    bus.I_READY = r;
    #1;
    if (bus.O_VALID && r && !f) popped.push_back(bus.O_ADDR);
    mpop = (q.size() != 0) && r && !f;
    mpush = v && !f && (q.size() < DEPTH || mpop);
    @(posedge clk);
    #1;
    if (f) begin
      q.delete();
      m_stall = 1'b0;
    end else begin
      if (v && q.size() == DEPTH && !mpop) m_ovf = 1'b1;
      if (mpop) void'(q.pop_front());
      if (mpush) q.push_back({a, d});
      m_stall = q.size() >= DEPTH - SKID;
    end
    check_outputs();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.I_VALID = 1'b0;
    bus.I_FLUSH = 1'b0;
    bus.I_READY = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    m_stall = 1'b0;
    m_ovf = 1'b0;
    check_outputs();
  endtask
  initial begin
    int pushed;
    logic rdy;
    bus.I_VALID = 1'b0;
    bus.I_ADDR = '0;
    bus.I_DATA = '0;
    bus.I_FLUSH = 1'b0;
    bus.I_READY = 1'b0;
    do_reset();
    chk("rst_valid", 64'(bus.O_VALID), 64'd0);
    chk("rst_count", 64'(bus.O_COUNT), 64'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'(4 * i), {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 1'b0, 1'b0);
    chk("tp_count3", 64'(bus.O_COUNT), 64'd3);
    chk("tp_head0", 64'(bus.O_ADDR), 64'd0);
    chk("tp_data0", 64'(bus.O_DATA), 64'h03020100);
    chk("tp_stall0", 64'(bus.O_STALL), 64'd0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
    chk("tp_drained", 64'(bus.O_VALID), 64'd0);
    for (int i = 0; i < 6; i++) begin
      chk("tp_stall_pre", 64'(bus.O_STALL), 64'd0);
      step(1'b1, 32'h40 + 32'(4 * i), $urandom, 1'b0, 1'b0);
    end
    chk("tp_stall_rise", 64'(bus.O_STALL), 64'd1);
    for (int i = 6; i < 8; i++) step(1'b1, 32'h40 + 32'(4 * i), $urandom, 1'b0, 1'b0);
    chk("tp_count8", 64'(bus.O_COUNT), 64'd8);
    chk("tp_ovf0", 64'(bus.O_OVERFLOW), 64'd0);
    step(1'b1, 32'h200, 32'hcafe0200, 1'b0, 1'b1);
    chk("tp_full_pp_count", 64'(bus.O_COUNT), 64'd8);
    chk("tp_full_pp_head", 64'(bus.O_ADDR), 64'h44);
    step(1'b1, 32'h204, 32'hdead0204, 1'b0, 1'b0);
    chk("tp_ovf1", 64'(bus.O_OVERFLOW), 64'd1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("tp_ovf_after_flush", 64'(bus.O_OVERFLOW), 64'd1);
    do_reset();
    chk("tp_ovf_cleared", 64'(bus.O_OVERFLOW), 64'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 32'h80 + 32'(4 * i), $urandom, 1'b0, 1'b0);
    step(1'b1, 32'h100, 32'h11111111, 1'b1, 1'b1);
    chk("tp_flush_valid", 64'(bus.O_VALID), 64'd0);
    chk("tp_flush_count", 64'(bus.O_COUNT), 64'd0);
    chk("tp_flush_stall", 64'(bus.O_STALL), 64'd0);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    popped.delete();
    pushed = 0;
    rdy = 1'b0;
    for (int c = 0; c < 200 && (pushed < 20 || q.size() != 0); c++) begin
      rdy = ~rdy;
      if (pushed < 20 && !m_stall) begin
        step(1'b1, 32'(4 * pushed), 32'hA5000000 + 32'(pushed), 1'b0, rdy);
        pushed++;
      end else step(1'b0, '0, '0, 1'b0, rdy);
    end
    chk("stream_len", 64'(popped.size()), 64'd20);
    for (int i = 0; i < popped.size() && i < 20; i++) chk("stream_addr", 64'(popped[i]), 64'(4 * i));
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      else step(m_stall ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
